// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter: data accesses normally win, and a bounded starvation
// counter forces an instruction fetch through after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  // instruction-fetch side
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  // data side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam int SCNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ram_state_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SCNT_W-1:0] scnt_q,  scnt_d;

  logic d_req;
  logic starved;
  logic ram_done;
  logic ram_err;

  assign d_req    = dREN | dWEN;
  assign starved  = iREN && (scnt_q == SCNT_MAX);
  assign ram_done = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
  assign ram_err  = (ramstate == RAM_ERROR);

  // Read data is a plain passthrough; the owner qualifies it with its wait.
  assign iload = ramload;
  assign dload = ramload;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  // NOTE: every output of this block is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_req && !starved) begin
          state_d = DGNT;
          if (!iREN)                 scnt_d = '0;
          else if (scnt_q != SCNT_MAX) scnt_d = scnt_q + 1'b1;
        end else if (iREN) begin
          state_d = IGNT;
          scnt_d  = '0;
        end else begin
          scnt_d  = '0;
        end
      end

      IGNT: begin
        if (!iREN) begin
          // Fetch withdrew its request: drop the RAM enables and give up the port.
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_done) begin
            iwait   = 1'b0;
            err     = ram_err;
            state_d = IDLE;
          end
        end
      end

      DGNT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = ~dWEN;
          if (ram_done) begin
            dwait   = 1'b0;
            err     = ram_err;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, request drivers and a
// completion scoreboard, plus cycle-exact checks for latency, abort and reset.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          iREN, dREN, dWEN;
  logic [AW-1:0] iaddr, daddr, ramaddr;
  logic [DW-1:0] dstore, iload, dload, ramstore, ramload;
  logic          iwait, dwait, ramREN, ramWEN, err;
  logic [1:0]    ramstate;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Expected completions, in the order the arbiter must serve them.
  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural RAM: ram_lat BUSY cycles, then ACCESS (or ERROR once if armed).
  int unsigned ram_lat      = 0;
  bit          ram_err_next = 1'b0;
  int unsigned ram_cnt      = 0;
  logic [31:0] mem [logic [31:0]];

  initial begin
    ramstate = 2'd0;
    ramload  = '0;
    mem[32'h100] = 32'hDEADBEEF;
    forever begin
      @(posedge CLK);
      #2;
      if (ramREN || ramWEN) begin
        if (ram_cnt < ram_lat) begin
          ramstate = 2'd1;
          ram_cnt++;
        end else begin
          if (ram_err_next) begin
            ramstate     = 2'd3;
            ramload      = '0;
            ram_err_next = 1'b0;
          end else begin
            ramstate = 2'd2;
            if (ramWEN) mem[ramaddr] = ramstore;
            else        ramload = mem.exists(ramaddr) ? mem[ramaddr] : ~ramaddr;
          end
          ram_cnt = 0;
        end
      end else begin
        ramstate = 2'd0;
        ram_cnt  = 0;
      end
    end
  end

  // Completion monitor / scoreboard, sampled mid-cycle.
  initial begin
    exp_t e;
    bit   gap_pending = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        check("wait_exclusive", {63'd0, (!iwait && !dwait)}, 64'd0);
        if (gap_pending) begin
          check("gap_enables", {62'd0, ramREN, ramWEN}, 64'd0);
          check("gap_waits",   {62'd0, iwait, dwait},   64'd3);
          gap_pending = 1'b0;
        end
        if (!iwait || !dwait) begin
          if (exp_q.size() == 0) begin
            check("unexpected_completion", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("owner_is_data", {63'd0, !dwait}, {63'd0, e.is_d});
            check("ram_addr", ramaddr, e.addr);
            check("err_flag", err, e.err);
            if (e.is_d && e.wr) begin
              check("wr_enables", {62'd0, ramWEN, ramREN}, 64'd2);
              check("wr_store", ramstore, e.data);
            end else if (e.is_d) begin
              check("rd_enables", {62'd0, ramWEN, ramREN}, 64'd1);
              if (!e.err) check("dload", dload, e.data);
            end else begin
              check("if_enables", {62'd0, ramWEN, ramREN}, 64'd1);
              check("iload", iload, e.data);
            end
          end
          gap_pending = 1'b1;
        end else begin
          check("err_quiet", err, 0);
        end
      end
    end
  end

  task automatic stim_tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic i_access(input logic [31:0] a);
    bit done = 1'b0;
    iREN  = 1'b1;
    iaddr = a;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge CLK);
      done = !iwait;
    end
    check("i_done", done, 1);
    stim_tick();
    iREN = 1'b0;
  endtask

  task automatic d_access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] dat);
    bit done = 1'b0;
    dREN   = rd;
    dWEN   = wr;
    daddr  = a;
    dstore = dat;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge CLK);
      done = !dwait;
    end
    check("d_done", done, 1);
    stim_tick();
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_iwait"},    iwait,    1);
    check({tag, "_dwait"},    dwait,    1);
    check({tag, "_ramREN"},   ramREN,   0);
    check({tag, "_ramWEN"},   ramWEN,   0);
    check({tag, "_ramaddr"},  ramaddr,  0);
    check({tag, "_ramstore"}, ramstore, 0);
    check({tag, "_err"},      err,      0);
  endtask

  initial begin
    logic [31:0] a;
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("reset");

    // Single fetch: BUSY twice, ACCESS in cycle 3, IDLE in cycle 4.
    ram_lat = 2;
    stim_tick();
    iREN  = 1'b1;
    iaddr = 32'h100;
    exp_q.push_back('{1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0});
    @(posedge CLK);
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      check("t1_ramREN",  ramREN,  1);
      check("t1_ramaddr", ramaddr, 32'h100);
      check("t1_iwait",   iwait,   (c == 3) ? 0 : 1);
    end
    stim_tick();
    iREN = 1'b0;
    @(negedge CLK);
    check("t1_idle_ramREN", ramREN, 0);
    check("t1_idle_iwait",  iwait,  1);

    // Data write and fetch raised together: write first, fetch after one IDLE.
    ram_lat = 0;
    stim_tick();
    exp_q.push_back('{1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0});
    exp_q.push_back('{1'b0, 1'b0, 32'h200, ~32'h200, 1'b0});
    fork
      d_access(1'b0, 1'b1, 32'h40, 32'h12345678);
      i_access(32'h200);
    join

    // Starvation bound: expected service order D,D,D,D,I,D,D,I.
    ram_lat = 1;
    for (int i = 0; i < 4; i++) begin
      a = 32'h40 + 32'(4 * i);
      exp_q.push_back('{1'b1, 1'b0, a, (a == 32'h40) ? 32'h12345678 : ~a, 1'b0});
    end
    exp_q.push_back('{1'b0, 1'b0, 32'h300, ~32'h300, 1'b0});
    exp_q.push_back('{1'b1, 1'b0, 32'h50, ~32'h50, 1'b0});
    exp_q.push_back('{1'b1, 1'b0, 32'h54, ~32'h54, 1'b0});
    exp_q.push_back('{1'b0, 1'b0, 32'h304, ~32'h304, 1'b0});
    fork
      for (int i = 0; i < 2; i++) i_access(32'h300 + 32'(4 * i));
      for (int i = 0; i < 6; i++) d_access(1'b1, 1'b0, 32'h40 + 32'(4 * i), 32'h0);
    join

    // dREN and dWEN together behave as a write; read it back.
    ram_lat = 0;
    exp_q.push_back('{1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 1'b0});
    d_access(1'b1, 1'b1, 32'h80, 32'hCAFEF00D);
    exp_q.push_back('{1'b1, 1'b0, 32'h80, 32'hCAFEF00D, 1'b0});
    d_access(1'b1, 1'b0, 32'h80, 32'h0);

    // ERROR completion during a data grant.
    ram_lat      = 1;
    ram_err_next = 1'b1;
    exp_q.push_back('{1'b1, 1'b0, 32'h84, 32'h0, 1'b1});
    d_access(1'b1, 1'b0, 32'h84, 32'h0);

    // Abort: dREN dropped while the RAM is BUSY.
    ram_lat = 5;
    dREN  = 1'b1;
    daddr = 32'h90;
    @(posedge CLK);
    @(negedge CLK);
    check("abort_granted", ramREN, 1);
    stim_tick();
    dREN = 1'b0;
    @(negedge CLK);
    check("abort_enables", {62'd0, ramREN, ramWEN}, 0);
    check("abort_dwait",   dwait, 1);
    stim_tick();
    @(negedge CLK);
    check("abort_idle_enables", {62'd0, ramREN, ramWEN}, 0);
    check("abort_idle_dwait",   dwait, 1);

    // The port is usable again after an abort.
    ram_lat = 0;
    exp_q.push_back('{1'b1, 1'b0, 32'h94, ~32'h94, 1'b0});
    d_access(1'b1, 1'b0, 32'h94, 32'h0);

    // Reset while a fetch is in IGNT.
    ram_lat = 5;
    iREN  = 1'b1;
    iaddr = 32'h500;
    @(posedge CLK);
    @(negedge CLK);
    check("rst_pre_ramREN",  ramREN,  1);
    check("rst_pre_ramaddr", ramaddr, 32'h500);
    stim_tick();
    RST = 1'b1;
    stim_tick();
    RST  = 1'b0;
    iREN = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midrst");

    repeat (3) @(posedge CLK);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
